// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - oversampled, majority-voted UART receiver with framing, parity and a one-word holding register
module uart_rx_framed #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_SIZE  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [WORD_SIZE-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W   = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_VOTE = IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_next;

    logic                 rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [IDX_W-1:0]     sample_idx;
    logic                 s0, s1;
    logic [WORD_SIZE-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity_err_n, frame_err_n;
    logic                 start_edge, tick, vote_tick, end_tick, vote, par_exp, done;

    assign start_edge = (state == S_IDLE) && rx_prev && !rx_sync;
    assign tick       = (div_cnt == DIV_LAST);
    assign vote_tick  = tick && (sample_idx == IDX_VOTE);
    assign end_tick   = tick && (sample_idx == IDX_LAST);
    assign vote       = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    assign par_exp    = (PARITY == 2) ? ~(^shreg) : (^shreg);
    assign busy       = (state != S_IDLE);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Tick divider and per-bit sample index; both realign to the start edge, early samples captured for the vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            sample_idx <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
        end else begin
            if (start_edge) begin
                div_cnt    <= '0;
                sample_idx <= '0;
            end else if (tick) begin
                div_cnt    <= '0;
                sample_idx <= (sample_idx == IDX_LAST) ? '0 : sample_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (tick && sample_idx == IDX_S0) s0 <= rx_sync;
            if (tick && sample_idx == IDX_S1) s1 <= rx_sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; the last stop vote returns to IDLE at once so a back-to-back start edge is seen
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            S_IDLE:   if (start_edge) state_next = S_START;
            S_START: begin
                if (vote_tick && vote) state_next = S_IDLE;
                else if (end_tick)     state_next = S_DATA;
            end
            S_DATA: begin
                if (end_tick && bit_cnt == BIT_LAST)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (end_tick) state_next = S_STOP;
            S_STOP: begin
                if (vote_tick && stop_cnt == STOP_LAST) begin
                    state_next = S_IDLE;
                    done       = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Frame datapath: LSB-first shift register, bit/stop counters and in-flight error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            parity_err_n <= 1'b0;
            frame_err_n  <= 1'b0;
        end else if (start_edge) begin
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            parity_err_n <= 1'b0;
            frame_err_n  <= 1'b0;
        end else begin
            if (state == S_DATA && vote_tick)            shreg <= {vote, shreg[WORD_SIZE-1:1]};
            if (state == S_DATA && end_tick)             bit_cnt <= bit_cnt + 1'b1;
            if (state == S_PARITY && vote_tick)          parity_err_n <= (vote != par_exp);
            if (state == S_STOP && vote_tick && !vote)   frame_err_n <= 1'b1;
            if (state == S_STOP && end_tick)             stop_cnt <= stop_cnt + 1'b1;
        end
    end

    // Holding register: load on completion when free or being accepted this cycle, else flag overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!data_valid || data_ready) begin
                    data       <= shreg;
                    parity_err <= parity_err_n;
                    frame_err  <= frame_err_n | ~vote;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed
module tb_uart_rx_framed;

    localparam int BIT0 = 432;
    localparam int BIT2 = 64;

    logic clk = 1'b0;
    logic rst;
    logic line;
    int   sel;
    logic rx0, rx1, rx2;
    logic rdy0, rdy1, rdy2;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic dv0, pe0, fe0, ov0, busy0;
    logic dv1, pe1, fe1, ov1, busy1;
    logic dv2, pe2, fe2, ov2, busy2;

    int checks = 0;
    int errors = 0;

    int acc0 = 0, acc1 = 0, acc2 = 0;
    int vcyc0 = 0;
    int ovc0 = 0, ovc1 = 0, ovc2 = 0;
    logic [7:0] last0_data = '0, last1_data = '0;
    logic [6:0] last2_data = '0;
    logic last0_pe = 1'b0, last0_fe = 1'b0;
    logic last1_pe = 1'b0, last1_fe = 1'b0;
    logic last2_pe = 1'b0, last2_fe = 1'b0;

    int base_acc, base_v, base_ov;

    assign rx0 = (sel == 0) ? line : 1'b1;
    assign rx1 = (sel == 1) ? line : 1'b1;
    assign rx2 = (sel == 2) ? line : 1'b1;

    always #10 clk = ~clk;

    uart_rx_framed u_dut (
        .clk(clk), .rst(rst), .rx(rx0), .data_ready(rdy0),
        .data(d0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0),
        .overrun(ov0), .busy(busy0)
    );

    uart_rx_framed #(.PARITY(1)) u_par (
        .clk(clk), .rst(rst), .rx(rx1), .data_ready(rdy1),
        .data(d1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1),
        .overrun(ov1), .busy(busy1)
    );

    uart_rx_framed #(.CLOCK_FREQ(7_372_800), .WORD_SIZE(7), .STOP_BITS(2)) u_w7 (
        .clk(clk), .rst(rst), .rx(rx2), .data_ready(rdy2),
        .data(d2), .data_valid(dv2), .parity_err(pe2), .frame_err(fe2),
        .overrun(ov2), .busy(busy2)
    );

    always @(negedge clk) begin
        if (dv0 && rdy0) begin
            acc0 <= acc0 + 1; last0_data <= d0; last0_pe <= pe0; last0_fe <= fe0;
        end
        if (dv0) vcyc0 <= vcyc0 + 1;
        if (ov0) ovc0 <= ovc0 + 1;
        if (dv1 && rdy1) begin
            acc1 <= acc1 + 1; last1_data <= d1; last1_pe <= pe1; last1_fe <= fe1;
        end
        if (ov1) ovc1 <= ovc1 + 1;
        if (dv2 && rdy2) begin
            acc2 <= acc2 + 1; last2_data <= d2; last2_pe <= pe2; last2_fe <= fe2;
        end
        if (ov2) ovc2 <= ovc2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int which, input int bit_clks, input int n, input logic [15:0] fr);
        sel  = which;
        line = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            line = fr[i];
            repeat (bit_clks) @(negedge clk);
        end
        line = 1'b1;
        repeat (6 * bit_clks) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b0;
        line = 1'b1;
        sel  = 0;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",  32'(d0), 0);
        check("rst_valid", 32'(dv0), 0);
        check("rst_perr",  32'(pe0), 0);
        check("rst_ferr",  32'(fe0), 0);
        check("rst_ovr",   32'(ov0), 0);
        check("rst_busy",  32'(busy0), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xAA with consumer ready
        base_acc = acc0; base_v = vcyc0;
        send_frame(0, BIT0, 9, {7'h0, 1'b1, 8'hAA});
        check("t1_count",   32'(acc0 - base_acc), 1);
        check("t1_data",    32'(last0_data), 32'hAA);
        check("t1_perr",    32'(last0_pe), 0);
        check("t1_ferr",    32'(last0_fe), 0);
        check("t1_vcycles", 32'(vcyc0 - base_v), 1);
        check("t1_busy",    32'(busy0), 0);

        // even parity: 0x07 needs parity bit 1
        base_acc = acc1;
        send_frame(1, BIT0, 10, {6'h0, 1'b1, 1'b0, 8'h07});
        check("t2_count_bad", 32'(acc1 - base_acc), 1);
        check("t2_data_bad",  32'(last1_data), 32'h07);
        check("t2_perr_bad",  32'(last1_pe), 1);
        check("t2_ferr_bad",  32'(last1_fe), 0);
        send_frame(1, BIT0, 10, {6'h0, 1'b1, 1'b1, 8'h07});
        check("t2_count_ok",  32'(acc1 - base_acc), 2);
        check("t2_data_ok",   32'(last1_data), 32'h07);
        check("t2_perr_ok",   32'(last1_pe), 0);

        // low stop bit, then a clean frame
        base_acc = acc0;
        send_frame(0, BIT0, 9, {7'h0, 1'b0, 8'hAA});
        check("t3_data_ferr", 32'(last0_data), 32'hAA);
        check("t3_ferr",      32'(last0_fe), 1);
        check("t3_perr",      32'(last0_pe), 0);
        send_frame(0, BIT0, 9, {7'h0, 1'b1, 8'h55});
        check("t3_count",     32'(acc0 - base_acc), 2);
        check("t3_data_next", 32'(last0_data), 32'h55);
        check("t3_ferr_next", 32'(last0_fe), 0);

        // false start: 3 ticks low
        base_acc = acc0;
        sel  = 0;
        line = 1'b0;
        repeat (81) @(negedge clk);
        check("t4_busy_start", 32'(busy0), 1);
        line = 1'b1;
        repeat (BIT0) @(negedge clk);
        check("t4_busy_idle", 32'(busy0), 0);
        repeat (2 * BIT0) @(negedge clk);
        check("t4_count", 32'(acc0 - base_acc), 0);
        check("t4_valid", 32'(dv0), 0);

        // overrun with stalled consumer
        rdy0 = 1'b0;
        base_acc = acc0; base_ov = ovc0;
        send_frame(0, BIT0, 9, {7'h0, 1'b1, 8'h11});
        send_frame(0, BIT0, 9, {7'h0, 1'b1, 8'h22});
        check("t5_held_valid", 32'(dv0), 1);
        check("t5_held_data",  32'(d0), 32'h11);
        check("t5_overrun",    32'(ovc0 - base_ov), 1);
        check("t5_no_accept",  32'(acc0 - base_acc), 0);
        rdy0 = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_valid_drop", 32'(dv0), 0);
        check("t5_accept",     32'(acc0 - base_acc), 1);
        check("t5_acc_data",   32'(last0_data), 32'h11);
        repeat (2 * BIT0) @(negedge clk);
        check("t5_no_second",  32'(acc0 - base_acc), 1);

        // reset in the middle of data bit 4
        base_acc = acc0; base_ov = ovc0;
        sel  = 0;
        line = 1'b0;
        repeat (BIT0) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line = i[0];
            repeat (BIT0) @(negedge clk);
        end
        line = 1'b0;
        repeat (200) @(negedge clk);
        check("t6_busy_mid", 32'(busy0), 1);
        rst = 1'b0;
        line = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_rst_data",  32'(d0), 0);
        check("t6_rst_valid", 32'(dv0), 0);
        check("t6_rst_perr",  32'(pe0), 0);
        check("t6_rst_ferr",  32'(fe0), 0);
        check("t6_rst_busy",  32'(busy0), 0);
        rst = 1'b1;
        repeat (6 * BIT0) @(negedge clk);
        check("t6_no_partial", 32'(acc0 - base_acc), 0);
        check("t6_no_ovr",     32'(ovc0 - base_ov), 0);
        send_frame(0, BIT0, 9, {7'h0, 1'b1, 8'h3C});
        check("t6_count", 32'(acc0 - base_acc), 1);
        check("t6_data",  32'(last0_data), 32'h3C);
        check("t6_errs",  32'({last0_pe, last0_fe}), 0);

        // 7 data bits, 2 stop bits
        base_acc = acc2;
        send_frame(2, BIT2, 9, {7'h0, 2'b11, 7'h5A});
        check("t7_count", 32'(acc2 - base_acc), 1);
        check("t7_data",  32'(last2_data), 32'h5A);
        check("t7_perr",  32'(last2_pe), 0);
        check("t7_ferr",  32'(last2_fe), 0);

        check("end_busy", 32'({busy0, busy1, busy2}), 0);
        check("end_ovr_par", 32'(ovc1), 0);
        check("end_ovr_w7",  32'(ovc2), 0);
        check("end_flags_w7", 32'({dv2, pe2, fe2, ov2}), 0);
        check("end_flags_par", 32'({dv1, fe1, ov1}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
